// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit: sequences each instruction through IF/ID/EXE/MEM/WB and drives datapath strobes.
// Optional retired-instruction counter output InsCount when INSN_COUNT_EN is defined.
module multicycle_control_fsm #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [OP_W-1:0]    Opcode,
    input  logic               zero,
    output logic               PCWre,
    output logic               IRWre,
    output logic               InsMemRW,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic               DBDataSrc,
    output logic               RegWre,
    output logic               WrRegDSrc,
    output logic [1:0]         RegDst,
    output logic               RD,
    output logic               WR,
    output logic               ExtSel,
    output logic [1:0]         PCSrc,
    output logic [ALUOP_W-1:0] ALUOp,
`ifdef INSN_COUNT_EN
    output logic [31:0]        InsCount,
`endif
    output logic [2:0]         State
);
    typedef enum logic [2:0] {
        S_IF = 3'b000, S_ID = 3'b001, S_EXE_LS = 3'b010, S_MEM = 3'b011,
        S_WB_LD = 3'b100, S_EXE_BR = 3'b101, S_EXE_AL = 3'b110, S_WB_AL = 3'b111
    } state_t;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_SLL = 3'b010,
                                   ALU_OR  = 3'b011, ALU_AND = 3'b100, ALU_SLT = 3'b101,
                                   ALU_XOR = 3'b110;

    state_t r_state, w_next;

    logic w_rtype, w_itype, w_lw, w_sw, w_beq, w_bne, w_j, w_jr, w_jal, w_halt, w_nop;
    logic w_srca, w_srcb, w_zext;
    logic [ALUOP_W-1:0] w_aluop;

    always_comb begin
        w_rtype = 1'b0; w_itype = 1'b0; w_lw = 1'b0; w_sw = 1'b0;
        w_beq = 1'b0; w_bne = 1'b0; w_j = 1'b0; w_jr = 1'b0; w_jal = 1'b0;
        w_halt = 1'b0; w_nop = 1'b0;
        w_srca = 1'b0; w_srcb = 1'b0; w_zext = 1'b0; w_aluop = ALU_ADD;
        case (Opcode)
            6'b000000: w_rtype = 1'b1;
            6'b000001: begin w_rtype = 1'b1; w_aluop = ALU_SUB; end
            6'b000010: begin w_itype = 1'b1; w_srcb = 1'b1; end
            6'b010000: begin w_rtype = 1'b1; w_aluop = ALU_AND; end
            6'b010001: begin w_itype = 1'b1; w_srcb = 1'b1; w_zext = 1'b1; w_aluop = ALU_AND; end
            6'b010010: begin w_itype = 1'b1; w_srcb = 1'b1; w_zext = 1'b1; w_aluop = ALU_OR; end
            6'b010011: begin w_itype = 1'b1; w_srcb = 1'b1; w_zext = 1'b1; w_aluop = ALU_XOR; end
            6'b010100: begin w_rtype = 1'b1; w_aluop = ALU_OR; end
            6'b011000: begin w_rtype = 1'b1; w_srca = 1'b1; w_aluop = ALU_SLL; end
            6'b100110: begin w_rtype = 1'b1; w_aluop = ALU_SLT; end
            6'b100111: begin w_itype = 1'b1; w_srcb = 1'b1; w_aluop = ALU_SLT; end
            6'b110000: begin w_sw = 1'b1; w_srcb = 1'b1; end
            6'b110001: begin w_lw = 1'b1; w_srcb = 1'b1; end
            6'b110100: begin w_beq = 1'b1; w_aluop = ALU_SUB; end
            6'b110101: begin w_bne = 1'b1; w_aluop = ALU_SUB; end
            6'b111000: w_j    = 1'b1;
            6'b111001: w_jr   = 1'b1;
            6'b111010: w_jal  = 1'b1;
            6'b111111: w_halt = 1'b1;
            default:   w_nop  = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) r_state <= S_IF;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IF:     w_next = S_ID;
            S_ID: begin
                if (w_halt)                w_next = S_ID;
                else if (w_rtype|w_itype)  w_next = S_EXE_AL;
                else if (w_lw | w_sw)      w_next = S_EXE_LS;
                else if (w_beq | w_bne)    w_next = S_EXE_BR;
                else                       w_next = S_IF;
            end
            S_EXE_LS: w_next = S_MEM;
            S_MEM:    w_next = w_lw ? S_WB_LD : S_IF;
            S_WB_LD:  w_next = S_IF;
            S_EXE_BR: w_next = S_IF;
            S_EXE_AL: w_next = S_WB_AL;
            S_WB_AL:  w_next = S_IF;
            default:  w_next = S_IF;
        endcase
    end

    always_comb begin
        PCWre = 1'b0; IRWre = 1'b0; InsMemRW = 1'b1; ALUSrcA = 1'b0; ALUSrcB = 1'b0;
        DBDataSrc = 1'b0; RegWre = 1'b0; WrRegDSrc = 1'b1; RegDst = 2'b00;
        RD = 1'b0; WR = 1'b0; ExtSel = 1'b1; PCSrc = 2'b00; ALUOp = ALU_ADD;
        // IR holds the previous instruction during IF, so datapath selects stay neutral there
        if (r_state != S_IF) begin
            ALUSrcA = w_srca;
            ALUSrcB = w_srcb;
            ExtSel  = ~w_zext;
            ALUOp   = w_aluop;
        end
        case (r_state)
            S_IF: IRWre = 1'b1;
            S_ID: begin
                if (w_j | w_jr | w_jal | w_nop) PCWre = 1'b1;
                if (w_j | w_jal) PCSrc = 2'b11;
                if (w_jr)        PCSrc = 2'b10;
                if (w_jal) begin
                    RegWre    = 1'b1;
                    RegDst    = 2'b00;
                    WrRegDSrc = 1'b0;
                end
            end
            S_EXE_BR: begin
                PCWre = 1'b1;
                if ((w_beq & zero) | (w_bne & ~zero)) PCSrc = 2'b01;
            end
            S_MEM: begin
                if (w_lw) begin RD = 1'b1; DBDataSrc = 1'b1; end
                if (w_sw) begin WR = 1'b1; PCWre = 1'b1; end
            end
            S_WB_LD: begin
                RegWre = 1'b1; RegDst = 2'b01; DBDataSrc = 1'b1; PCWre = 1'b1;
            end
            S_WB_AL: begin
                RegWre = 1'b1; RegDst = w_rtype ? 2'b10 : 2'b01; PCWre = 1'b1;
            end
            default: ;
        endcase
    end

    assign State = r_state;

`ifdef INSN_COUNT_EN
    logic [31:0] r_ins_count;
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)      r_ins_count <= 32'd0;
        else if (PCWre) r_ins_count <= r_ins_count + 32'd1;
    end
    assign InsCount = r_ins_count;
`endif
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed-vector bench for multicycle_control_fsm; expected values are hand-derived constants.
module tb_multicycle_control_fsm;
    logic       CLK, Reset, zero;
    logic [5:0] Opcode;
    logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, DBDataSrc, RegWre, WrRegDSrc, RD, WR, ExtSel;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] ALUOp, State;
`ifdef INSN_COUNT_EN
    logic [31:0] InsCount;
`endif

    int n_vec = 0;
    int n_err = 0;

    multicycle_control_fsm dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .DBDataSrc(DBDataSrc), .RegWre(RegWre), .WrRegDSrc(WrRegDSrc), .RegDst(RegDst),
        .RD(RD), .WR(WR), .ExtSel(ExtSel), .PCSrc(PCSrc), .ALUOp(ALUOp),
`ifdef INSN_COUNT_EN
        .InsCount(InsCount),
`endif
        .State(State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Opcode = 6'b110001; zero = 1'b0;
        #3;
        chk("rst_state", State, 3'b000);
        chk("rst_irwre", IRWre, 1);
        chk("rst_insmem", InsMemRW, 1);
        chk("rst_extsel", ExtSel, 1);
        chk("rst_wrregdsrc", WrRegDSrc, 1);
        chk("rst_pcwre", PCWre, 0);
        chk("rst_regwre", RegWre, 0);
        chk("rst_pcsrc", PCSrc, 0);
        chk("rst_aluop", ALUOp, 0);
        chk("rst_alusrcb", ALUSrcB, 0);
        tick();
        chk("rst_hold_state", State, 3'b000);
        Reset = 1'b0;

        // lw: 000,001,010,011,100,000
        tick(); chk("lw_id", State, 3'b001); chk("lw_id_pcwre", PCWre, 0); chk("lw_id_irwre", IRWre, 0);
        tick(); chk("lw_ls", State, 3'b010); chk("lw_ls_srcb", ALUSrcB, 1); chk("lw_ls_aluop", ALUOp, 3'b000);
        tick(); chk("lw_mem", State, 3'b011); chk("lw_mem_rd", RD, 1); chk("lw_mem_wr", WR, 0);
        chk("lw_mem_db", DBDataSrc, 1); chk("lw_mem_regwre", RegWre, 0); chk("lw_mem_pcwre", PCWre, 0);
        tick(); chk("lw_wb", State, 3'b100); chk("lw_wb_regwre", RegWre, 1); chk("lw_wb_regdst", RegDst, 2'b01);
        chk("lw_wb_db", DBDataSrc, 1); chk("lw_wb_pcwre", PCWre, 1); chk("lw_wb_rd", RD, 0);
        tick(); chk("lw_if", State, 3'b000); chk("lw_if_irwre", IRWre, 1);

        // beq then bne, both zero polarities in EXE_BR
        Opcode = 6'b110100; zero = 1'b1;
        tick(); chk("beq_id", State, 3'b001);
        tick(); chk("beq_br", State, 3'b101); chk("beq_z1_pcsrc", PCSrc, 2'b01); chk("beq_pcwre", PCWre, 1);
        chk("beq_aluop", ALUOp, 3'b001);
        zero = 1'b0; #1; chk("beq_z0_pcsrc", PCSrc, 2'b00); chk("beq_z0_pcwre", PCWre, 1);
        tick(); chk("beq_if", State, 3'b000);
        Opcode = 6'b110101;
        tick(); chk("bne_id", State, 3'b001);
        tick(); chk("bne_z0_pcsrc", PCSrc, 2'b01);
        zero = 1'b1; #1; chk("bne_z1_pcsrc", PCSrc, 2'b00);
        tick(); chk("bne_if", State, 3'b000);

        // jal retires in ID
        Opcode = 6'b111010;
        tick(); chk("jal_id", State, 3'b001); chk("jal_regwre", RegWre, 1); chk("jal_regdst", RegDst, 2'b00);
        chk("jal_wrregdsrc", WrRegDSrc, 0); chk("jal_pcsrc", PCSrc, 2'b11); chk("jal_pcwre", PCWre, 1);
        tick(); chk("jal_if", State, 3'b000);

        // ori: I-type, zero-extended
        Opcode = 6'b010010;
        tick(); chk("ori_id", State, 3'b001); chk("ori_id_pcwre", PCWre, 0);
        tick(); chk("ori_exe", State, 3'b110); chk("ori_srcb", ALUSrcB, 1); chk("ori_extsel", ExtSel, 0);
        chk("ori_aluop", ALUOp, 3'b011);
        tick(); chk("ori_wb", State, 3'b111); chk("ori_regwre", RegWre, 1); chk("ori_regdst", RegDst, 2'b01);
        chk("ori_pcwre", PCWre, 1);
        tick(); chk("ori_if", State, 3'b000);

        // sll: R-type using sa
        Opcode = 6'b011000;
        tick();
        tick(); chk("sll_exe", State, 3'b110); chk("sll_srca", ALUSrcA, 1); chk("sll_aluop", ALUOp, 3'b010);
        chk("sll_srcb", ALUSrcB, 0);
        tick(); chk("sll_regdst", RegDst, 2'b10); chk("sll_regwre", RegWre, 1);
        tick(); chk("sll_if", State, 3'b000);

        // nop (undefined opcode) and jr
        Opcode = 6'b000111;
        tick(); chk("nop_pcwre", PCWre, 1); chk("nop_pcsrc", PCSrc, 2'b00); chk("nop_regwre", RegWre, 0);
        tick(); chk("nop_if", State, 3'b000);
        Opcode = 6'b111001;
        tick(); chk("jr_pcsrc", PCSrc, 2'b10); chk("jr_pcwre", PCWre, 1);
        tick(); chk("jr_if", State, 3'b000);

        // sw, async reset while in MEM
        Opcode = 6'b110000;
        tick(); tick();
        tick(); chk("sw_mem", State, 3'b011); chk("sw_wr", WR, 1); chk("sw_rd", RD, 0); chk("sw_pcwre", PCWre, 1);
        #2 Reset = 1'b1;
        #1; chk("sw_rst_wr", WR, 0); chk("sw_rst_state", State, 3'b000); chk("sw_rst_irwre", IRWre, 1);
        chk("sw_rst_pcwre", PCWre, 0);
        Reset = 1'b0;
        tick(); chk("sw_post_rst", State, 3'b001);
        tick(); tick(); chk("sw_mem2", State, 3'b011);
        tick(); chk("sw_if", State, 3'b000);

        // halt holds ID
        Opcode = 6'b111111;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick(); chk("halt_state", State, 3'b001); chk("halt_pcwre", PCWre, 0);
        end
        Reset = 1'b1; #1; Reset = 1'b0;
        chk("halt_rst_state", State, 3'b000);

`ifdef INSN_COUNT_EN
        chk("cnt_rst", InsCount, 0);
        Opcode = 6'b000000; repeat (4) tick();
        Opcode = 6'b010010; repeat (4) tick();
        Opcode = 6'b110000; repeat (4) tick();
        Opcode = 6'b111000; repeat (2) tick();
        chk("cnt_four", InsCount, 4);
        chk("cnt_state", State, 3'b000);
        Opcode = 6'b111111;
        tick();
        repeat (20) tick();
        chk("cnt_halt", InsCount, 4);
        Reset = 1'b1; #1; Reset = 1'b0;
        chk("cnt_clr", InsCount, 0);
        Opcode = 6'b111000;
        force dut.r_ins_count = 32'hFFFF_FFFF;
        #1; release dut.r_ins_count;
        tick(); chk("cnt_pre", InsCount, 32'hFFFF_FFFF);
        tick(); chk("cnt_wrap", InsCount, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
